// File: rtl/mycpu_pkg.sv
// Shared pipeline definitions: EXE->MEM and MEM->WB bus layouts, load-op indices
// and exception-cause numbering.
package mycpu_pkg;

  localparam int ES_TO_MS_BUS_W = 144;
  localparam int MS_TO_WS_BUS_W = 137;
  localparam int EX_W           = 17;
  localparam int EXC_ALE        = 3;
  localparam int LD_OP_W        = 5;

  localparam int LD_B  = 0;
  localparam int LD_BU = 1;
  localparam int LD_H  = 2;
  localparam int LD_HU = 3;
  localparam int LD_W  = 4;

  typedef struct packed {
    logic               mem_we;
    logic               rdcntid;
    logic               ertn;
    logic               csr_we;
    logic               csr_rd;
    logic [31:0]        csr_wmask;
    logic [13:0]        csr_num;
    logic [EX_W-1:0]    ex_cause;
    logic [LD_OP_W-1:0] ld_op;
    logic               res_from_mem;
    logic               gr_we;
    logic [4:0]         dest;
    logic [31:0]        result;
    logic [31:0]        pc;
  } es_to_ms_t;

  typedef struct packed {
    logic            rdcntid;
    logic            ertn;
    logic            csr_we;
    logic            csr_rd;
    logic [31:0]     csr_wmask;
    logic [13:0]     csr_num;
    logic [EX_W-1:0] ex_cause;
    logic            gr_we;
    logic [4:0]      dest;
    logic [31:0]     final_result;
    logic [31:0]     pc;
  } ms_to_ws_t;

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
    return {{24{sgn & b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
    return {{16{sgn & h[15]}}, h};
  endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half out of the SRAM word and sign/zero-extends it;
// ld_w (or no load op) passes the word through.
module load_align
  import mycpu_pkg::*;
(
  input  logic [LD_OP_W-1:0] ld_op_i,
  input  logic [1:0]         off_i,
  input  logic [31:0]        rdata_i,
  output logic [31:0]        data_o
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (off_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    data_o = rdata_i;
    if      (ld_op_i[LD_B])  data_o = ext8(byte_sel, 1'b1);
    else if (ld_op_i[LD_BU]) data_o = ext8(byte_sel, 1'b0);
    else if (ld_op_i[LD_H])  data_o = ext16(half_sel, 1'b1);
    else if (ld_op_i[LD_HU]) data_o = ext16(half_sel, 1'b0);
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: waits for the data-SRAM response, aligns load data, forwards to WB
// and drops responses owed to flushed instructions. Optional macro: MEM_LOAD_BYPASS_EN.
module mem_stage
  import mycpu_pkg::*;
#(
  parameter int CANCEL_CNT_W = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ws_allowin,
  output logic                      ms_allowin,
  input  logic                      es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_W-1:0] es_to_ms_bus,
  input  logic                      es_mem_req_hs,
  input  logic                      data_sram_data_ok,
  input  logic [31:0]               data_sram_rdata,
  output logic                      ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_W-1:0] ms_to_ws_bus,
  output logic [4:0]                ms_to_ds_dest,
  output logic [31:0]               ms_to_ds_value,
  output logic                      ms_value_pending,
  input  logic                      ws_reflush_ms,
  output logic                      ms_int,
  output logic                      ms_csr,
  output logic                      ms_tid
);
  localparam int CW1 = CANCEL_CNT_W + 1;

  es_to_ms_t               ms_bus_q;
  logic                    ms_valid_q, ms_valid_d;
  logic                    data_ok_q, data_ok_d;
  logic [31:0]             rdata_q, rdata_d;
  logic [CANCEL_CNT_W-1:0] cancel_cnt_q, cancel_cnt_d;
  logic [CW1-1:0]          cnt_sum;

  logic        has_exc, req_sent, data_ok_hit, data_ok_drop, ms_ready_go, owed_resp;
  logic [31:0] ld_word, aligned, final_result;
  ms_to_ws_t   ws_bus;

  assign has_exc      = |ms_bus_q.ex_cause;
  assign req_sent     = (ms_bus_q.res_from_mem | ms_bus_q.mem_we) & ~has_exc;
  assign data_ok_hit  = data_sram_data_ok & (cancel_cnt_q == '0);
  assign data_ok_drop = data_sram_data_ok & (cancel_cnt_q != '0);
  assign ms_ready_go  = ~req_sent | data_ok_hit | data_ok_q;

  assign ms_allowin     = ~ms_valid_q | (ms_ready_go & ws_allowin);
  assign ms_to_ws_valid = ms_valid_q & ms_ready_go & ~ws_reflush_ms;

  // Once WB stalls past data_ok the SRAM word is gone, so later cycles use the captured copy.
  assign ld_word = data_ok_q ? rdata_q : data_sram_rdata;

  load_align u_load_align (
    .ld_op_i (ms_bus_q.ld_op),
    .off_i   (ms_bus_q.result[1:0]),
    .rdata_i (ld_word),
    .data_o  (aligned)
  );

  // Faulting loads keep result so WB can report the bad address.
  assign final_result = (ms_bus_q.res_from_mem & ~has_exc) ? aligned : ms_bus_q.result;

  always_comb begin
    ws_bus.rdcntid      = ms_bus_q.rdcntid;
    ws_bus.ertn         = ms_bus_q.ertn;
    ws_bus.csr_we       = ms_bus_q.csr_we;
    ws_bus.csr_rd       = ms_bus_q.csr_rd;
    ws_bus.csr_wmask    = ms_bus_q.csr_wmask;
    ws_bus.csr_num      = ms_bus_q.csr_num;
    ws_bus.ex_cause     = ms_bus_q.ex_cause;
    ws_bus.gr_we        = ms_bus_q.gr_we;
    ws_bus.dest         = ms_bus_q.dest;
    ws_bus.final_result = final_result;
    ws_bus.pc           = ms_bus_q.pc;
  end
  assign ms_to_ws_bus = ws_bus;

  // A flushed request still in flight (ours or one EXE just got accepted) owes a data_ok to drop.
  assign owed_resp = ms_valid_q & req_sent & ~data_ok_q & ~data_ok_hit;

  always_comb begin
    cnt_sum = {1'b0, cancel_cnt_q} - CW1'(data_ok_drop);
    if (ws_reflush_ms)
      cnt_sum = cnt_sum + CW1'(owed_resp) + CW1'(es_mem_req_hs);
    cancel_cnt_d = cnt_sum[CANCEL_CNT_W-1:0];
  end

  always_comb begin
    ms_valid_d = ms_valid_q;
    if (ws_reflush_ms)   ms_valid_d = 1'b0;
    else if (ms_allowin) ms_valid_d = es_to_ms_valid;

    data_ok_d = data_ok_q;
    rdata_d   = rdata_q;
    if (ws_reflush_ms || (ms_ready_go && ws_allowin)) begin
      data_ok_d = 1'b0;
      rdata_d   = '0;
    end else if (data_ok_hit && ms_valid_q) begin
      data_ok_d = 1'b1;
      rdata_d   = data_sram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid_q   <= 1'b0;
      ms_bus_q     <= '0;
      data_ok_q    <= 1'b0;
      rdata_q      <= '0;
      cancel_cnt_q <= '0;
    end else begin
      ms_valid_q   <= ms_valid_d;
      data_ok_q    <= data_ok_d;
      rdata_q      <= rdata_d;
      cancel_cnt_q <= cancel_cnt_d;
      if (es_to_ms_valid && ms_allowin)
        ms_bus_q <= es_to_ms_bus;
      assert (!cnt_sum[CANCEL_CNT_W]);
    end
  end

  assign ms_to_ds_dest = (ms_valid_q & ms_bus_q.gr_we) ? ms_bus_q.dest : 5'd0;
`ifdef MEM_LOAD_BYPASS_EN
  assign ms_value_pending = ms_valid_q & ms_bus_q.res_from_mem & ~ms_ready_go;
  assign ms_to_ds_value   = final_result;
`else
  assign ms_value_pending = ms_valid_q & ms_bus_q.res_from_mem;
  assign ms_to_ds_value   = ms_bus_q.result;
`endif
  assign ms_int = ms_valid_q & (has_exc | ms_bus_q.ertn);
  assign ms_csr = ms_valid_q & (ms_bus_q.csr_rd | ms_bus_q.csr_we);
  assign ms_tid = ms_valid_q & ms_bus_q.rdcntid;

endmodule
